// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with a 2-bit saturating counter per entry; zero-latency lookup, MEM-stage training.
// Optional statistics counters are enabled by defining BP_STATS_EN.
module branch_target_predictor #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned TAG_W    = 8,
    parameter logic [1:0]  CTR_INIT = 2'b01,
    parameter int unsigned STATS_W  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_is_jump,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [XLEN-1:0] upd_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] correct_pc
`ifdef BP_STATS_EN
    ,
    output logic [STATS_W-1:0] stat_updates,
    output logic [STATS_W-1:0] stat_mispredicts
`endif
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0] valid_q;
    logic [1:0]         ctr_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;

    logic       up_wr;
    logic       tgt_wr;
    logic       tag_wr;
    logic [1:0] ctr_d;

    // Lookup: purely combinational on registered table state.
    always_comb begin
        lk_idx      = if_pc[IDX_W+1:2];
        lk_tag      = if_pc[IDX_W+TAG_W+1:IDX_W+2];
        lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken  = if_valid && lk_hit && ctr_q[lk_idx][1];
        pred_target = pred_taken ? target_q[lk_idx] : if_pc + XLEN'(4);
    end

    // Resolution check; forced low while reset is asserted.
    always_comb begin
        mispredict = rst && upd_valid &&
                     ((upd_taken != upd_pred_taken) ||
                      (upd_taken && (upd_target != upd_pred_target)));
        correct_pc = (upd_valid && upd_taken) ? upd_target : upd_pc + XLEN'(4);
    end

    always_comb begin
        up_idx = upd_pc[IDX_W+1:2];
        up_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
        up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        up_wr  = 1'b0;
        tgt_wr = 1'b0;
        tag_wr = 1'b0;
        ctr_d  = ctr_q[up_idx];
        if (upd_valid) begin
            if (up_hit) begin
                up_wr = 1'b1;
                if (upd_is_jump) begin
                    ctr_d  = 2'b11;
                    tgt_wr = 1'b1;
                end else if (upd_taken) begin
                    ctr_d  = (ctr_q[up_idx] == 2'b11) ? 2'b11 : ctr_q[up_idx] + 2'd1;
                    tgt_wr = 1'b1;
                end else begin
                    ctr_d  = (ctr_q[up_idx] == 2'b00) ? 2'b00 : ctr_q[up_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                // Allocate by overwriting whatever entry sits at this index.
                up_wr  = 1'b1;
                tgt_wr = 1'b1;
                tag_wr = 1'b1;
                ctr_d  = upd_is_jump ? 2'b11 : 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_INIT;
            end
        end else if (up_wr) begin
            valid_q[up_idx] <= 1'b1;
            ctr_q[up_idx]   <= ctr_d;
        end
    end

    // Tags and targets are qualified by valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (rst && tgt_wr) begin
            target_q[up_idx] <= upd_target;
        end
        if (rst && tag_wr) begin
            tag_q[up_idx] <= up_tag;
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_updates     <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (upd_valid && (stat_updates != '1)) begin
                stat_updates <= stat_updates + STATS_W'(1);
            end
            if (mispredict && (stat_mispredicts != '1)) begin
                stat_mispredicts <= stat_mispredicts + STATS_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench for branch_target_predictor: directed scenarios plus randomized traffic
// compared every cycle against a table-level behavioural model.
module tb_branch_target_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_jump;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] correct_pc;
`ifdef BP_STATS_EN
    logic [31:0] stat_updates;
    logic [31:0] stat_mispredicts;
`endif

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Model: one record per table slot, counters kept as plain integers 0..3.
    bit          m_valid [16];
    int          m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    longint      m_upd;
    longint      m_mis;

    branch_target_predictor dut (
        .clk             (clk),
        .rst             (rst),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_is_jump     (upd_is_jump),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .correct_pc      (correct_pc)
`ifdef BP_STATS_EN
        ,
        .stat_updates    (stat_updates),
        .stat_mispredicts(stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    function automatic int slot(logic [31:0] pc);
        return int'((pc >> 2) % 16);
    endfunction

    function automatic int tag_of(logic [31:0] pc);
        return int'((pc >> 6) % 256);
    endfunction

    function automatic bit m_hit(logic [31:0] pc);
        return m_valid[slot(pc)] && (m_tag[slot(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_pred(logic [31:0] pc);
        return m_hit(pc) && (m_ctr[slot(pc)] >= 2);
    endfunction

    function automatic bit exp_mis();
        if (!rst || !upd_valid) return 1'b0;
        if (upd_taken != upd_pred_taken) return 1'b1;
        return upd_taken && (upd_target != upd_pred_target);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_upd = 0;
        m_mis = 0;
    endtask

    task automatic model_update();
        int i;
        if (!upd_valid) return;
        i = slot(upd_pc);
        m_upd++;
        if (exp_mis()) m_mis++;
        if (m_hit(upd_pc)) begin
            if (upd_is_jump) begin
                m_ctr[i] = 3;
                m_tgt[i] = upd_target;
            end else if (upd_taken) begin
                m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                m_tgt[i] = upd_target;
            end else begin
                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
        end else if (upd_taken) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = tag_of(upd_pc);
            m_tgt[i]   = upd_target;
            m_ctr[i]   = upd_is_jump ? 3 : 2;
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic        et;
            logic [31:0] ep;
            et = if_valid && m_pred(if_pc);
            ep = et ? m_tgt[slot(if_pc)] : if_pc + 32'd4;
            check("model_pred_taken", {31'd0, pred_taken}, {31'd0, et});
            check("model_pred_target", pred_target, ep);
            check("model_mispredict", {31'd0, mispredict}, {31'd0, exp_mis()});
            check("model_correct_pc", correct_pc,
                  (upd_valid && upd_taken) ? upd_target : upd_pc + 32'd4);
`ifdef BP_STATS_EN
            check("model_stat_updates", stat_updates, 32'(m_upd));
            check("model_stat_mispredicts", stat_mispredicts, 32'(m_mis));
`endif
        end
    end

    task automatic lookup(bit v, logic [31:0] pc);
        if_valid = v;
        if_pc    = pc;
    endtask

    task automatic upd(bit v, logic [31:0] pc, bit j, bit t, logic [31:0] tg, bit pt,
                       logic [31:0] ptg);
        upd_valid       = v;
        upd_pc          = pc;
        upd_is_jump     = j;
        upd_taken       = t;
        upd_target      = tg;
        upd_pred_taken  = pt;
        upd_pred_target = ptg;
    endtask

    task automatic no_upd();
        upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Model follows the DUT's clock edge; inputs change 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (rst) model_update();
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #0;
    endtask

    initial begin
        rst = 1'b0;
        model_reset();
        lookup(1'b1, 32'h40);
        no_upd();
        #2;
        check("reset_pred_taken", {31'd0, pred_taken}, 32'd0);
        check("reset_pred_target", pred_target, 32'h44);
        lookup(1'b1, 32'hFFFF_FFFC);
        #1;
        check("reset_wrap_target", pred_target, 32'h0);
        check("reset_mispredict", {31'd0, mispredict}, 32'd0);
        at_neg();
        #2;
        rst    = 1'b1;
        chk_en = 1'b1;
        tick();

        // Cold miss, taken branch: mispredict then allocation.
        lookup(1'b1, 32'h40);
        upd(1'b1, 32'h40, 1'b0, 1'b1, 32'h20, 1'b0, 32'h44);
        at_neg();
        check("alloc_mispredict", {31'd0, mispredict}, 32'd1);
        check("alloc_correct_pc", correct_pc, 32'h20);
        check("alloc_same_cycle_pred", {31'd0, pred_taken}, 32'd0);
        tick();
        no_upd();
        at_neg();
        check("alloc_pred_taken", {31'd0, pred_taken}, 32'd1);
        check("alloc_pred_target", pred_target, 32'h20);
        tick();

        // Hysteresis walk: 10 -> 01 -> 10 -> 11 -> 10.
        upd(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20);
        tick();
        no_upd();
        at_neg();
        check("hyst_01_not_taken", {31'd0, pred_taken}, 32'd0);
        check("hyst_01_target", pred_target, 32'h44);
        for (int k = 0; k < 2; k++) begin
            upd(1'b1, 32'h40, 1'b0, 1'b1, 32'h20, 1'b0, 32'h44);
            tick();
        end
        upd(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20);
        at_neg();
        check("hyst_nt_mispredict", {31'd0, mispredict}, 32'd1);
        check("hyst_nt_correct_pc", correct_pc, 32'h44);
        tick();
        no_upd();
        at_neg();
        check("hyst_10_still_taken", {31'd0, pred_taken}, 32'd1);
        tick();

        // Alias at the same index with a different tag.
        lookup(1'b1, 32'h80);
        at_neg();
        check("alias_miss", {31'd0, pred_taken}, 32'd0);
        check("alias_miss_target", pred_target, 32'h84);
        upd(1'b1, 32'h80, 1'b1, 1'b1, 32'h100, 1'b0, 32'h84);
        tick();
        no_upd();
        at_neg();
        check("alias_jal_target", pred_target, 32'h100);
        tick();
        lookup(1'b1, 32'h40);
        at_neg();
        check("alias_evicted", {31'd0, pred_taken}, 32'd0);
        tick();

        // Retrain 0x40, then lookup and update in the same cycle: no bypass.
        upd(1'b1, 32'h40, 1'b0, 1'b1, 32'h20, 1'b0, 32'h44);
        tick();
        upd(1'b1, 32'h40, 1'b0, 1'b1, 32'h60, 1'b1, 32'h20);
        at_neg();
        check("same_cycle_old_target", pred_target, 32'h20);
        check("same_cycle_target_mis", {31'd0, mispredict}, 32'd1);
        tick();
        no_upd();
        at_neg();
        check("same_cycle_new_target", pred_target, 32'h60);
        tick();

        // Asynchronous reset mid-cycle, with an update pending.
        upd(1'b1, 32'h40, 1'b0, 1'b1, 32'h60, 1'b0, 32'h44);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("async_rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        check("async_rst_mispredict", {31'd0, mispredict}, 32'd0);
`ifdef BP_STATS_EN
        check("async_rst_stat_upd", stat_updates, 32'd0);
        check("async_rst_stat_mis", stat_mispredicts, 32'd0);
`endif
        tick();
        #2;
        rst = 1'b1;
        no_upd();
        at_neg();
        check("post_rst_dropped", {31'd0, pred_taken}, 32'd0);
        tick();

        // Randomized traffic over a small PC pool to force hits and aliasing.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] lp;
            logic [31:0] up;
            bit          j;
            bit          t;
            lp = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            up = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
            if ($urandom_range(0, 31) == 0) lp = 32'hFFFF_FFFC;
            lookup($urandom_range(0, 7) != 0, lp);
            j = ($urandom_range(0, 5) == 0);
            t = j || ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) != 0) begin
                upd(1'b1, up, j, t, {$urandom_range(0, 255), 2'b00},
                    m_pred(up), m_pred(up) ? m_tgt[slot(up)] : up + 32'd4);
            end else begin
                upd($urandom_range(0, 1) == 1, up, j, t, $urandom, $urandom_range(0, 1) == 1,
                    $urandom);
            end
            if ($urandom_range(0, 499) == 0) begin
                #2;
                rst = 1'b0;
                model_reset();
                #2;
                rst = 1'b1;
            end
            tick();
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
